adder_accumulator: RTL and testbench
====================================

# adder_accumulator

Downstream stage of the 4-bit ripple adder: consumes each `{cout, sum}` result and accumulates a fixed number of them into a wider running total. The total is presented on a valid/ready output port. Input and output use independent valid/ready handshakes. A small FSM sequences collection, result hold and release.

## Interface
- `N_SAMPLES`, default 4: adder results summed per output word; legal range 1..15.
- `ACC_W`, default 8: accumulator width; legal range 5..16.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `clear`  in  1  synchronous abort; discards the partial total.
- `in_valid`  in  1  `sum`/`cout` carry a new adder result.
- `sum`  in  4  adder sum bits.
- `cout`  in  1  adder carry-out.
- `in_ready`  out  1  block can accept a result this cycle.
- `out_valid`  out  1  `acc`/`overflow` hold a completed total.
- `out_ready`  in  1  consumer takes the total this cycle.
- `acc`  out  ACC_W  running or final total.
- `overflow`  out  1  sticky; the total wrapped past 2^ACC_W.
- `count`  out  4  results accepted in the current word.

## Operation
- Operand value = `{cout, sum}`, a 5-bit unsigned value from 0 to 31, zero-extended to ACC_W bits.
- FSM states:
  - IDLE: count = 0, acc = 0.
  - ACCUM: 0 < count < N_SAMPLES.
  - DONE: result held.
- `in_ready` = 1 in IDLE and ACCUM, 0 in DONE. It is decoded from the registered state only.
- Accept condition: `in_valid && in_ready` at a rising edge. On accept:
  - acc <= acc + value, modulo 2^ACC_W.
  - count <= count + 1.
  - overflow <= overflow | carry out of bit ACC_W-1.
- State transitions:
  - From IDLE or ACCUM, the accept that brings count to N_SAMPLES moves to DONE.
  - Otherwise the first accept moves IDLE to ACCUM.
  - With N_SAMPLES = 1, IDLE goes directly to DONE.
- `out_valid` = 1 exactly in DONE.
- In DONE, `acc`, `overflow` and `count` (= N_SAMPLES) hold stable until `out_ready` = 1.
- On `out_valid && out_ready`: acc <= 0, count <= 0, overflow <= 0, state <= IDLE.
- `in_valid` is ignored in DONE. A result presented in the same cycle as the output transfer is not accepted; the upstream source must hold it.
- Priority: `rst` > `clear` > handshakes.
- `clear` = 1 in any state forces IDLE, acc = 0, count = 0, overflow = 0. A concurrent input is dropped and a concurrent output transfer does not occur.
- Output values after reset:
  - `acc` = 0
  - `count` = 0
  - `overflow` = 0
  - `out_valid` = 0
  - `in_ready` = 1

## Timing
- Inputs are sampled only at rising edges. No combinational path runs from `in_valid` or `out_ready` to any output.
- `acc` and `count` update in the cycle after each accept.
- Minimum latency is N_SAMPLES cycles. With `in_valid` held high, `out_valid` rises at the edge of the Nth accept.
- Minimum word period is N_SAMPLES + 1 cycles: N accept cycles plus at least one DONE cycle. `in_ready` = 0 for exactly the DONE cycles.
- Gaps in `in_valid` hold state, acc and count unchanged.
- Reset asserted mid-word or in DONE takes effect at the next edge. The word is lost and no output transfer occurs.

## Test plan
- Basic word (N=4, ACC_W=8):
  - Stimulus: accept values 3 (a=1, b=2, cin=0), 6 (4+1+1), 13 (12+0+1), 12 (12+0+0) on consecutive cycles, `out_ready`=1.
  - Response: acc = 0x22, `out_valid` high for one cycle after the 4th accept, `overflow` = 0, then IDLE with acc = 0.
- Overflow (ACC_W=6, N=4):
  - Stimulus: accept `{cout=1, sum=15}` (31) four times.
  - Response: acc = 60 (124 mod 64), `overflow` = 1 in DONE, cleared after the transfer.
- Backpressure:
  - Stimulus: complete a word with `out_ready`=0 for 5 cycles while `in_valid`=1.
  - Response: `out_valid`, acc and count stable; `in_ready` = 0; no input absorbed. Transfer on the 6th cycle, then the next input is accepted.
- Bubbles:
  - Stimulus: accept 5, idle 3 cycles, accept 1, 1, 2.
  - Response: acc = 9 in DONE; count steps 1, 1, 1, 1, 2, 3, 4.
- Clear mid-word:
  - Stimulus: after 2 accepts (acc=7), assert `clear` together with `in_valid` (value 4).
  - Response: acc = 0, count = 0, IDLE; the value 4 is not accumulated.
- Reset in DONE:
  - Stimulus: assert `rst` while `out_valid`=1 and `out_ready`=0.
  - Response: next cycle `out_valid` = 0, acc = 0, `in_ready` = 1.

Source files
------------

// File: rtl/adder_accumulator.sv
// Accumulates N_SAMPLES 5-bit adder results ({cout, sum}) into an ACC_W-bit total
// and offers the total on a valid/ready port; a three-state FSM sequences the word.
module adder_accumulator #(
  parameter int N_SAMPLES = 4,
  parameter int ACC_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             in_valid,
  input  logic [3:0]       sum,
  input  logic             cout,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] acc,
  output logic             overflow,
  output logic [3:0]       count
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam logic [3:0] LP_N = 4'(N_SAMPLES);

  state_t           r_state, w_state_next;
  logic [ACC_W-1:0] r_acc, w_acc_next;
  logic [3:0]       r_count, w_count_next;
  logic             r_overflow, w_overflow_next;
  logic [ACC_W:0]   w_operand;
  logic [ACC_W:0]   w_sum_ext;
  logic [3:0]       w_count_inc;

  // One extra bit on the adder exposes the carry out of bit ACC_W-1 for the sticky flag.
  assign w_operand   = {{(ACC_W-4){1'b0}}, cout, sum};
  assign w_sum_ext   = {1'b0, r_acc} + w_operand;
  assign w_count_inc = r_count + 4'd1;

  always_comb begin
    w_state_next    = r_state;
    w_acc_next      = r_acc;
    w_count_next    = r_count;
    w_overflow_next = r_overflow;
    if (clear) begin
      w_state_next    = S_IDLE;
      w_acc_next      = '0;
      w_count_next    = '0;
      w_overflow_next = 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_ACCUM: begin
          if (in_valid) begin
            w_acc_next      = w_sum_ext[ACC_W-1:0];
            w_count_next    = w_count_inc;
            w_overflow_next = r_overflow | w_sum_ext[ACC_W];
            w_state_next    = (w_count_inc == LP_N) ? S_DONE : S_ACCUM;
          end
        end
        S_DONE: begin
          // Inputs presented during the release cycle are not taken.
          if (out_ready) begin
            w_state_next    = S_IDLE;
            w_acc_next      = '0;
            w_count_next    = '0;
            w_overflow_next = 1'b0;
          end
        end
        default: begin
          w_state_next    = S_IDLE;
          w_acc_next      = '0;
          w_count_next    = '0;
          w_overflow_next = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_acc      <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_acc      <= w_acc_next;
      r_count    <= w_count_next;
      r_overflow <= w_overflow_next;
    end
  end

  assign in_ready  = (r_state != S_DONE);
  assign out_valid = (r_state == S_DONE);
  assign acc       = r_acc;
  assign overflow  = r_overflow;
  assign count     = r_count;

endmodule

// File: tb/tb_adder_accumulator.sv
// Self-checking bench: main instance (N=4, ACC_W=6) against a running-total model,
// plus a single-sample instance (N=1, ACC_W=5) for the direct IDLE-to-DONE path.
module tb_adder_accumulator;

  localparam int N  = 4;
  localparam int W  = 6;
  localparam int W1 = 5;

  logic         clk = 1'b0;
  logic         rst, clear, in_valid, cout, out_ready;
  logic [3:0]   sum;
  logic         in_ready, out_valid, overflow;
  logic [W-1:0] acc;
  logic [3:0]   count;

  logic          s_clear, s_in_valid, s_cout, s_out_ready;
  logic [3:0]    s_sum;
  logic          s_in_ready, s_out_valid, s_overflow;
  logic [W1-1:0] s_acc;
  logic [3:0]    s_count;

  int errors = 0;
  int checks = 0;

  // Model: total of values accepted in the current word, how many, and whether held.
  int m_total = 0;
  int m_cnt   = 0;
  bit m_done  = 1'b0;

  adder_accumulator #(.N_SAMPLES(N), .ACC_W(W)) u_dut (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .sum(sum), .cout(cout),
    .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
    .acc(acc), .overflow(overflow), .count(count)
  );

  adder_accumulator #(.N_SAMPLES(1), .ACC_W(W1)) u_dut1 (
    .clk(clk), .rst(rst), .clear(s_clear), .in_valid(s_in_valid), .sum(s_sum), .cout(s_cout),
    .in_ready(s_in_ready), .out_valid(s_out_valid), .out_ready(s_out_ready),
    .acc(s_acc), .overflow(s_overflow), .count(s_count)
  );

  always #5 clk = ~clk;

  function automatic int exp_acc();
    return m_total % (1 << W);
  endfunction

  function automatic bit exp_ovf();
    return (m_total >= (1 << W));
  endfunction

  // Drive one cycle of inputs, advance the model at the edge, settle 1 time unit.
  task automatic cycle(input bit v, input logic [4:0] val, input bit rdy, input bit clr, input bit r);
    in_valid = v; cout = val[4]; sum = val[3:0]; out_ready = rdy; clear = clr; rst = r;
    @(posedge clk);
    if (r || clr || (m_done && rdy)) begin
      m_total = 0; m_cnt = 0; m_done = 1'b0;
    end else if (!m_done && v) begin
      m_total += int'(val);
      m_cnt++;
      if (m_cnt == N) m_done = 1'b1;
    end
    #1;
    $display("cyc v=%0b val=%0d rdy=%0b clr=%0b rst=%0b -> acc=%0d cnt=%0d ov=%0b ovld=%0b ir=%0b",
             v, val, rdy, clr, r, acc, count, overflow, out_valid, in_ready);
  endtask

  task automatic test_reset();
    cycle(0, 5'd0, 0, 0, 1);
    cycle(0, 5'd0, 0, 0, 1);
    checks++;
    if (acc !== '0 || count !== 4'd0 || overflow !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset: acc=%0d cnt=%0d ov=%0b ovld=%0b ir=%0b, required 0 0 0 0 1",
               acc, count, overflow, out_valid, in_ready);
    end
    checks++;
    if (s_acc !== '0 || s_count !== 4'd0 || s_out_valid !== 1'b0 || s_in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_n1: acc=%0d cnt=%0d ovld=%0b ir=%0b, required 0 0 0 1",
               s_acc, s_count, s_out_valid, s_in_ready);
    end
    cycle(0, 5'd0, 0, 0, 0);
  endtask

  task automatic test_basic_word();
    logic [4:0] vals [4] = '{5'd3, 5'd6, 5'd13, 5'd12};
    for (int i = 0; i < 4; i++) begin
      cycle(1, vals[i], 1, 0, 0);
      checks++;
      if (acc !== W'(exp_acc()) || count !== 4'(m_cnt) || out_valid !== m_done) begin
        errors++;
        $display("FAIL basic_step%0d: acc=%0d cnt=%0d ovld=%0b, required %0d %0d %0b",
                 i, acc, count, out_valid, exp_acc(), m_cnt, m_done);
      end
    end
    checks++;
    if (acc !== W'(34) || out_valid !== 1'b1 || overflow !== 1'b0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL basic_done: acc=%0d ovld=%0b ov=%0b ir=%0b, required 34 1 0 0",
               acc, out_valid, overflow, in_ready);
    end
    cycle(0, 5'd0, 1, 0, 0);
    checks++;
    if (acc !== '0 || count !== 4'd0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL basic_release: acc=%0d cnt=%0d ovld=%0b ir=%0b, required 0 0 0 1",
               acc, count, out_valid, in_ready);
    end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 4; i++) cycle(1, 5'd31, 0, 0, 0);
    checks++;
    if (acc !== W'(60) || overflow !== 1'b1 || out_valid !== 1'b1 || count !== 4'd4) begin
      errors++;
      $display("FAIL overflow_done: acc=%0d ov=%0b ovld=%0b cnt=%0d, required 60 1 1 4",
               acc, overflow, out_valid, count);
    end
    cycle(0, 5'd0, 1, 0, 0);
    checks++;
    if (overflow !== 1'b0 || acc !== '0) begin
      errors++;
      $display("FAIL overflow_release: ov=%0b acc=%0d, required 0 0", overflow, acc);
    end
  endtask

  task automatic test_backpressure();
    int total = 0;
    logic [4:0] v;
    for (int i = 0; i < 4; i++) begin
      v = 5'($urandom_range(0, 15));
      total += int'(v);
      cycle(1, v, 0, 0, 0);
    end
    for (int i = 0; i < 5; i++) begin
      cycle(1, 5'($urandom_range(1, 31)), 0, 0, 0);
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || acc !== W'(total) || count !== 4'd4) begin
        errors++;
        $display("FAIL backpressure_hold%0d: ovld=%0b ir=%0b acc=%0d cnt=%0d, required 1 0 %0d 4",
                 i, out_valid, in_ready, acc, count, total);
      end
    end
    cycle(1, 5'd9, 1, 0, 0);
    checks++;
    if (out_valid !== 1'b0 || acc !== '0 || count !== 4'd0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL backpressure_transfer: ovld=%0b acc=%0d cnt=%0d ir=%0b, required 0 0 0 1",
               out_valid, acc, count, in_ready);
    end
    cycle(1, 5'd7, 0, 0, 0);
    checks++;
    if (acc !== W'(7) || count !== 4'd1) begin
      errors++;
      $display("FAIL backpressure_next: acc=%0d cnt=%0d, required 7 1", acc, count);
    end
    cycle(0, 5'd0, 0, 1, 0);
  endtask

  task automatic test_bubbles();
    bit         vs   [7] = '{1, 0, 0, 0, 1, 1, 1};
    logic [4:0] vals [7] = '{5'd5, 5'd0, 5'd0, 5'd0, 5'd1, 5'd1, 5'd2};
    int         cnts [7] = '{1, 1, 1, 1, 2, 3, 4};
    for (int i = 0; i < 7; i++) begin
      cycle(vs[i], vals[i], 0, 0, 0);
      checks++;
      if (count !== 4'(cnts[i])) begin
        errors++;
        $display("FAIL bubbles_count%0d: cnt=%0d, required %0d", i, count, cnts[i]);
      end
    end
    checks++;
    if (acc !== W'(9) || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL bubbles_done: acc=%0d ovld=%0b, required 9 1", acc, out_valid);
    end
    cycle(0, 5'd0, 1, 0, 0);
  endtask

  task automatic test_clear();
    cycle(1, 5'd3, 0, 0, 0);
    cycle(1, 5'd4, 0, 0, 0);
    checks++;
    if (acc !== W'(7) || count !== 4'd2) begin
      errors++;
      $display("FAIL clear_pre: acc=%0d cnt=%0d, required 7 2", acc, count);
    end
    cycle(1, 5'd4, 0, 1, 0);
    checks++;
    if (acc !== '0 || count !== 4'd0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL clear_mid: acc=%0d cnt=%0d ir=%0b ovld=%0b, required 0 0 1 0",
               acc, count, in_ready, out_valid);
    end
    for (int i = 0; i < 4; i++) cycle(1, 5'd2, 0, 0, 0);
    cycle(0, 5'd0, 1, 1, 0);
    checks++;
    if (out_valid !== 1'b0 || acc !== '0 || count !== 4'd0) begin
      errors++;
      $display("FAIL clear_done: ovld=%0b acc=%0d cnt=%0d, required 0 0 0", out_valid, acc, count);
    end
  endtask

  task automatic test_reset_in_done();
    for (int i = 0; i < 4; i++) cycle(1, 5'd10, 0, 0, 0);
    checks++;
    if (out_valid !== 1'b1 || acc !== W'(40)) begin
      errors++;
      $display("FAIL rstdone_pre: ovld=%0b acc=%0d, required 1 40", out_valid, acc);
    end
    cycle(0, 5'd0, 0, 0, 1);
    checks++;
    if (out_valid !== 1'b0 || acc !== '0 || in_ready !== 1'b1 || count !== 4'd0) begin
      errors++;
      $display("FAIL rstdone: ovld=%0b acc=%0d ir=%0b cnt=%0d, required 0 0 1 0",
               out_valid, acc, in_ready, count);
    end
    cycle(0, 5'd0, 0, 0, 0);
  endtask

  task automatic test_single_sample();
    s_in_valid = 1'b1; s_cout = 1'b1; s_sum = 4'd4; s_out_ready = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (s_out_valid !== 1'b1 || s_acc !== W1'(20) || s_count !== 4'd1 || s_in_ready !== 1'b0) begin
      errors++;
      $display("FAIL n1_done: ovld=%0b acc=%0d cnt=%0d ir=%0b, required 1 20 1 0",
               s_out_valid, s_acc, s_count, s_in_ready);
    end
    s_cout = 1'b0; s_sum = 4'd5; s_out_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (s_out_valid !== 1'b0 || s_acc !== '0 || s_count !== 4'd0) begin
      errors++;
      $display("FAIL n1_release: ovld=%0b acc=%0d cnt=%0d, required 0 0 0", s_out_valid, s_acc, s_count);
    end
    s_out_ready = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (s_out_valid !== 1'b1 || s_acc !== W1'(5) || s_overflow !== 1'b0) begin
      errors++;
      $display("FAIL n1_second: ovld=%0b acc=%0d ov=%0b, required 1 5 0", s_out_valid, s_acc, s_overflow);
    end
    s_in_valid = 1'b0; s_out_ready = 1'b1;
    @(posedge clk); #1;
    s_out_ready = 1'b0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom % 4) != 0, 5'($urandom), ($urandom % 3) != 0,
            ($urandom % 25) == 0, ($urandom % 80) == 0);
      checks++;
      if (acc !== W'(exp_acc()) || count !== 4'(m_cnt) || overflow !== exp_ovf() ||
          out_valid !== m_done || in_ready !== !m_done) begin
        errors++;
        $display("FAIL random%0d: acc=%0d cnt=%0d ov=%0b ovld=%0b ir=%0b, required %0d %0d %0b %0b %0b",
                 i, acc, count, overflow, out_valid, in_ready,
                 exp_acc(), m_cnt, exp_ovf(), m_done, !m_done);
      end
    end
  endtask

  initial begin
    rst = 1'b1; clear = 1'b0; in_valid = 1'b0; cout = 1'b0; sum = 4'd0; out_ready = 1'b0;
    s_clear = 1'b0; s_in_valid = 1'b0; s_cout = 1'b0; s_sum = 4'd0; s_out_ready = 1'b0;
    #1;
    test_reset();
    test_basic_word();
    test_overflow();
    test_backpressure();
    test_bubbles();
    test_clear();
    test_reset_in_done();
    test_single_sample();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
